hdmi_line_packer: RTL and testbench



---
 rtl/hdmi_line_packer_pkg.sv | 21 ++
 rtl/hdmi_line_packer_if.sv | 10 +
 rtl/hdmi_line_packer_bit_packer.sv | 61 ++++++
 rtl/hdmi_line_packer.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_line_packer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_line_packer_pkg.sv
// Shared types and constants for the HDMI-to-LCD line packer.
// State encodings, packet width and words-per-line helper.
package fpga_lcd_pkg;

  typedef enum logic [1:0] {
    s_WAIT_FRAME,
    s_WAIT_LINE,
    s_ACTIVE,
    s_PAD
  } state_e;

  localparam int PACK_WIDTH      = 32;
  localparam int LINE_PIXELS_DEF = 1280;
  localparam int WORDS_PER_LINE  = LINE_PIXELS_DEF / PACK_WIDTH;

  // Words per line for a given active line width.
  function automatic int words_per_line(int lp);
    return lp / PACK_WIDTH;
  endfunction

endpackage

// File: rtl/hdmi_line_packer_if.sv
// FIFO write-side bus of the line packer.
// master: drives data/valid, sees full; slave: the FIFO side.
interface hdmi_line_packer_if;
  logic [31:0] data;
  logic        valid;
  logic        full;

  modport master (output data, output valid, input full);
  modport slave  (input data, input valid, output full);
endinterface

// File: rtl/hdmi_line_packer_bit_packer.sv
// 32-bit pixel-bit shift register with fill count and zero-fill flush.
// Ports: shift_i/bit_i in, flush_i, clear_i; word_o/complete_o out.
module bit_packer
  import fpga_lcd_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  shift_i,
  input  logic                  bit_i,
  input  logic                  flush_i,
  input  logic                  clear_i,
  output logic [PACK_WIDTH-1:0] word_o,
  output logic                  complete_o
);

  localparam int FW = $clog2(PACK_WIDTH);

  logic [PACK_WIDTH-1:0] sr_q, sr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [PACK_WIDTH-1:0] shifted;

  assign shifted = {sr_q[PACK_WIDTH-2:0], bit_i};

  always_comb begin
    sr_d       = sr_q;
    fill_d     = fill_q;
    word_o     = sr_q;
    complete_o = 1'b0;
    if (clear_i) begin
      sr_d   = '0;
      fill_d = '0;
    end else if (shift_i) begin
      word_o = shifted;
      if (fill_q == FW'(PACK_WIDTH - 1)) begin
        complete_o = 1'b1;
        sr_d       = '0;
        fill_d     = '0;
      end else begin
        sr_d   = shifted;
        fill_d = fill_q + FW'(1);
      end
    end else if (flush_i) begin
      // Left-justify the partial word so the first pixel lands in bit 31.
      word_o     = sr_q << (7'(PACK_WIDTH) - {2'b00, fill_q});
      complete_o = (fill_q != '0);
      sr_d       = '0;
      fill_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/hdmi_line_packer.sv
// Packs 24-bit RGB into 1-bpp 32-pixel words with line/frame alignment.
// Ports: HDMI clock/reset, pixel/DE/vSync/enable in; FIFO word/strobe, flags out.
module hdmi_line_packer
  import fpga_lcd_pkg::*;
#(
  parameter int LINE_PIXELS = 1280,
  parameter int FRAME_LINES = 1280,
  parameter int THRESHOLD   = 384
) (
  input  logic        i_hdmiClock,
  input  logic        i_reset,
  input  logic [23:0] i_hdmiData,
  input  logic        i_dataEnable,
  input  logic        i_vSync,
  input  logic        i_hdmiEnable,
  input  logic        i_fifoFull,
  output logic [31:0] o_fifoData,
  output logic        o_dataValid,
  output logic        o_frameActive,
  output logic        o_overflow,
  output logic        o_syncError
);

  localparam int WPL = words_per_line(LINE_PIXELS);
  localparam int PW  = $clog2(LINE_PIXELS + 1);
  localparam int LW  = $clog2(FRAME_LINES + 1);
  localparam int WW  = $clog2(WPL + 1);

  state_e         state_q, state_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic [LW-1:0]  line_q, line_d;
  logic [WW-1:0]  word_q, word_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           active_q, active_d;
  logic           ovf_q, ovf_d;
  logic           serr_q, serr_d;
  logic           vs_q;
  logic           armed_q;

  logic           pk_shift, pk_flush, pk_clear;
  logic           pk_complete;
  logic [31:0]    pk_word;
  logic           pad_wr, line_end;
  logic           vs_rise;
  logic [9:0]     sum;
  logic           lit;

  assign sum = {2'b00, i_hdmiData[23:16]}
             + {2'b00, i_hdmiData[15:8]}
             + {2'b00, i_hdmiData[7:0]};
  assign lit = (sum >= 10'(THRESHOLD));

  // armed_q masks the first sample after reset so a vSync already
  // high at release is not seen as an edge.
  assign vs_rise = armed_q & i_vSync & ~vs_q;

  bit_packer u_packer (
    .clk_i      (i_hdmiClock),
    .rst_i      (i_reset),
    .shift_i    (pk_shift),
    .bit_i      (lit),
    .flush_i    (pk_flush),
    .clear_i    (pk_clear),
    .word_o     (pk_word),
    .complete_o (pk_complete)
  );

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    line_d   = line_q;
    word_d   = word_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    serr_d   = serr_q;
    pk_shift = 1'b0;
    pk_flush = 1'b0;
    pk_clear = 1'b0;
    pad_wr   = 1'b0;
    line_end = 1'b0;

    if (vs_rise && state_q != s_WAIT_FRAME) begin
      pk_clear = 1'b1;
      serr_d   = 1'b1;
      pix_d    = '0;
      word_d   = '0;
      line_d   = '0;
      state_d  = i_hdmiEnable ? s_WAIT_LINE : s_WAIT_FRAME;
    end else begin
      unique case (state_q)
        s_WAIT_FRAME: begin
          if (vs_rise && i_hdmiEnable) begin
            line_d  = '0;
            pix_d   = '0;
            word_d  = '0;
            state_d = s_WAIT_LINE;
          end
        end
        s_WAIT_LINE: begin
          if (i_dataEnable) begin
            pk_shift = 1'b1;
            pix_d    = PW'(1);
            state_d  = s_ACTIVE;
          end
        end
        s_ACTIVE: begin
          if (i_dataEnable) begin
            if (pix_q < PW'(LINE_PIXELS)) begin
              pk_shift = 1'b1;
              pix_d    = pix_q + PW'(1);
            end else begin
              serr_d = 1'b1;
            end
          end else if (pix_q == PW'(LINE_PIXELS)) begin
            line_end = 1'b1;
          end else begin
            serr_d   = 1'b1;
            pk_flush = 1'b1;
            state_d  = s_PAD;
          end
        end
        s_PAD: begin
          if (i_dataEnable) begin
            serr_d   = 1'b1;
            pk_shift = 1'b1;
            pix_d    = PW'(1);
            word_d   = '0;
            state_d  = s_ACTIVE;
          end else if (word_q < WW'(WPL)) begin
            pad_wr   = 1'b1;
            line_end = (word_q + WW'(1) == WW'(WPL));
          end else begin
            line_end = 1'b1;
          end
        end
        default: state_d = s_WAIT_FRAME;
      endcase
    end

    // A dropped word still counts so the line stays aligned.
    if (pk_complete || pad_wr) begin
      word_d = word_q + WW'(1);
      if (i_fifoFull) begin
        ovf_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = pad_wr ? 32'd0 : pk_word;
      end
    end

    if (line_end) begin
      line_d  = line_q + LW'(1);
      pix_d   = '0;
      word_d  = '0;
      state_d = (line_q + LW'(1) == LW'(FRAME_LINES))
              ? s_WAIT_FRAME : s_WAIT_LINE;
    end

    active_d = (state_d != s_WAIT_FRAME);
  end

  always_ff @(posedge i_hdmiClock) begin
    if (i_reset) begin
      state_q  <= s_WAIT_FRAME;
      pix_q    <= '0;
      line_q   <= '0;
      word_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
      serr_q   <= 1'b0;
      vs_q     <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      word_q   <= word_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      ovf_q    <= ovf_d;
      serr_q   <= serr_d;
      vs_q     <= i_vSync;
      armed_q  <= 1'b1;
    end
  end

  assign o_fifoData    = data_q;
  assign o_dataValid   = valid_q;
  assign o_frameActive = active_q;
  assign o_overflow    = ovf_q;
  assign o_syncError   = serr_q;

endmodule

// File: tb/tb_hdmi_line_packer.sv
// Scoreboard bench for hdmi_line_packer on a reduced 128x8 raster.
// Expected words come from a pixel model; a monitor pops on each strobe.
module tb_hdmi_line_packer;

  localparam int LP  = 128;
  localparam int FL  = 8;
  localparam int THR = 384;
  localparam int WPL = LP / 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] data;
  logic        de, vs, en, full;
  logic [31:0] fdata;
  logic        fvalid, active, ovf, serr;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  hdmi_line_packer_if fifo ();
  assign fifo.data  = fdata;
  assign fifo.valid = fvalid;
  assign fifo.full  = full;

  always #5 clk = ~clk;

  hdmi_line_packer #(
    .LINE_PIXELS (LP),
    .FRAME_LINES (FL),
    .THRESHOLD   (THR)
  ) dut (
    .i_hdmiClock   (clk),
    .i_reset       (rst),
    .i_hdmiData    (data),
    .i_dataEnable  (de),
    .i_vSync       (vs),
    .i_hdmiEnable  (en),
    .i_fifoFull    (fifo.full),
    .o_fifoData    (fdata),
    .o_dataValid   (fvalid),
    .o_frameActive (active),
    .o_overflow    (ovf),
    .o_syncError   (serr)
  );

  // Scoreboard monitor: every strobe must match the next expected word.
  always @(negedge clk) begin
    if (!rst && fifo.valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%08h required=none", fifo.data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fifo.data !== e) begin
          errors++;
          $display("FAIL word got=%08h required=%08h", fifo.data, e);
        end
      end
    end
  end

  function automatic logic [23:0] pix(int kind, int idx);
    case (kind)
      0: return (idx % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      1: return 24'hFFFFFF;
      default: begin
        case (idx % 5)
          0: return 24'h808080;
          1: return 24'h7F7F7F;
          2: return 24'hFF8100;
          3: return 24'hC8B700;
          default: return 24'hFFFFFF;
        endcase
      end
    endcase
  endfunction

  function automatic logic lit(logic [23:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return s >= THR;
  endfunction

  // Model of one line's FIFO output: full words, zero-filled partial,
  // then zero pad to WPL. Words completing while full is held are dropped.
  task automatic model_line(int kind, int n, int flo, int fhi, bit push);
    logic [31:0] w;
    int nb, words, r;
    w = '0;
    words = 0;
    nb = (n > LP) ? LP : n;
    for (int i = 0; i < nb; i++) begin
      w = {w[30:0], lit(pix(kind, i))};
      if (i % 32 == 31) begin
        if (push && !(i >= flo && i <= fhi)) exp_q.push_back(w);
        words++;
      end
    end
    r = nb % 32;
    if (r != 0) begin
      w = w << (32 - r);
      if (push) exp_q.push_back(w);
      words++;
    end
    while (words < WPL) begin
      if (push) exp_q.push_back(32'd0);
      words++;
    end
  endtask

  task automatic drive_line(int kind, int n, int flo, int fhi, bit push);
    model_line(kind, n, flo, fhi, push);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      de   = 1'b1;
      data = pix(kind, i);
      full = (i >= flo && i <= fhi);
    end
    @(negedge clk);
    de   = 1'b0;
    data = '0;
    full = 1'b0;
    repeat (WPL + 4) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    de   = 1'b0;
    vs   = 1'b0;
    full = 1'b0;
    en   = 1'b1;
    data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic check_drain(string name);
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got=%0d_pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bit(string name, logic got, logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%b required=%b", name, got, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got=%08h required=00000000", fdata);
    end
    check_bit("reset_valid", fvalid, 1'b0);
    check_bit("reset_active", active, 1'b0);
    check_bit("reset_overflow", ovf, 1'b0);
    check_bit("reset_syncerr", serr, 1'b0);
  endtask

  task automatic test_frame();
    do_reset();
    vsync_pulse();
    check_bit("frame_active_start", active, 1'b1);
    for (int l = 0; l < FL; l++) drive_line(0, LP, -1, -1, 1'b1);
    check_bit("frame_active_end", active, 1'b0);
    check_bit("frame_syncerr", serr, 1'b0);
    check_bit("frame_overflow", ovf, 1'b0);
    check_drain("frame");
  endtask

  task automatic test_threshold();
    do_reset();
    vsync_pulse();
    drive_line(2, LP, -1, -1, 1'b1);
    check_bit("thr_syncerr", serr, 1'b0);
    check_drain("threshold");
  endtask

  task automatic test_short_line();
    do_reset();
    vsync_pulse();
    drive_line(1, 70, -1, -1, 1'b1);
    check_bit("short_syncerr", serr, 1'b1);
    drive_line(0, LP, -1, -1, 1'b1);
    check_drain("short");
  endtask

  task automatic test_long_line();
    do_reset();
    vsync_pulse();
    drive_line(1, LP + 5, -1, -1, 1'b1);
    check_bit("long_syncerr", serr, 1'b1);
    check_drain("long");
  endtask

  task automatic test_overflow();
    do_reset();
    vsync_pulse();
    drive_line(1, LP, 32, 95, 1'b1);
    drive_line(0, LP, -1, -1, 1'b1);
    check_bit("ovf_flag", ovf, 1'b1);
    check_bit("ovf_syncerr", serr, 1'b0);
    check_drain("overflow");
  endtask

  task automatic test_vsync_mid();
    do_reset();
    vsync_pulse();
    for (int l = 0; l < 3; l++) drive_line(0, LP, -1, -1, 1'b1);
    exp_q.push_back(32'hFFFFFFFF);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      de   = 1'b1;
      data = pix(1, i);
    end
    @(negedge clk);
    de = 1'b0;
    vs = 1'b1;
    repeat (3) @(negedge clk);
    vs = 1'b0;
    repeat (6) @(negedge clk);
    check_bit("vmid_syncerr", serr, 1'b1);
    for (int l = 0; l < FL - 1; l++) drive_line(0, LP, -1, -1, 1'b1);
    check_bit("vmid_active_before_last", active, 1'b1);
    drive_line(0, LP, -1, -1, 1'b1);
    check_bit("vmid_active_after_last", active, 1'b0);
    check_drain("vsync_mid");
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    vsync_pulse();
    check_bit("en_off_active", active, 1'b0);
    drive_line(1, LP, -1, -1, 1'b0);
    check_bit("en_off_active_after", active, 1'b0);
    en = 1'b1;
    vsync_pulse();
    check_bit("en_on_active", active, 1'b1);
    drive_line(0, LP, -1, -1, 1'b1);
    check_drain("enable");
  endtask

  initial begin
    rst  = 1'b1;
    de   = 1'b0;
    vs   = 1'b0;
    en   = 1'b1;
    full = 1'b0;
    data = '0;
    test_reset();
    test_frame();
    test_threshold();
    test_short_line();
    test_long_line();
    test_overflow();
    test_vsync_mid();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
